// File: rtl/ps2_frame_receiver_if.sv
// Bus between the PS/2 pins, the frame receiver and the scan-code consumer.
// The receiver sits on the master side: it reads the pins and drives the scan-code outputs.
interface ps2_frame_receiver_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       break_flag;
    logic       ext_flag;
    logic       frame_err;

    modport master (
        input  ps2_clk,
        input  ps2_data,
        output scan_code,
        output scan_valid,
        output break_flag,
        output ext_flag,
        output frame_err
    );

    modport slave (
        output ps2_clk,
        output ps2_data,
        input  scan_code,
        input  scan_valid,
        input  break_flag,
        input  ext_flag,
        input  frame_err
    );
endinterface

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: synchronises the pins, deframes 11-bit frames,
// folds 0xE0/0xF0 prefixes into flags and times out frames that stall mid-way.
module ps2_frame_receiver #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ps2_frame_receiver_if.master bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic             clk_s1, clk_s2, clk_prev;
    logic             data_s1, data_s2;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             parity_ok;
    logic [CNT_W-1:0] idle_cnt;
    logic             pending_break;
    logic             pending_ext;
    logic [7:0]       scan_code_r;
    logic             scan_valid_r;
    logic             break_flag_r;
    logic             ext_flag_r;
    logic             frame_err_r;

    logic fall;
    logic timeout;

    assign fall    = clk_prev & ~clk_s2;
    // A falling edge in the same cycle wins over a timeout.
    assign timeout = (state != IDLE) && (idle_cnt == TIMEOUT_VAL) && !fall;

    // NOTE: every register below is assigned with <= so all flops update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_s1        <= 1'b1;
            clk_s2        <= 1'b1;
            clk_prev      <= 1'b1;
            data_s1       <= 1'b1;
            data_s2       <= 1'b1;
            state         <= IDLE;
            bit_cnt       <= 3'd0;
            shift_reg     <= 8'h00;
            parity_ok     <= 1'b0;
            idle_cnt      <= '0;
            pending_break <= 1'b0;
            pending_ext   <= 1'b0;
            scan_code_r   <= 8'h00;
            scan_valid_r  <= 1'b0;
            break_flag_r  <= 1'b0;
            ext_flag_r    <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            clk_s1       <= bus.ps2_clk;
            clk_s2       <= clk_s1;
            clk_prev     <= clk_s2;
            data_s1      <= bus.ps2_data;
            data_s2      <= data_s1;
            scan_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;

            if (fall) begin
                idle_cnt <= '0;
            end else if (idle_cnt != TIMEOUT_VAL) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (fall) begin
                unique case (state)
                    IDLE: begin
                        if (!data_s2) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        shift_reg <= {data_s2, shift_reg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    PARITY: begin
                        parity_ok <= (^shift_reg) ^ data_s2;
                        state     <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (parity_ok && data_s2) begin
                            if (shift_reg == 8'hF0) begin
                                pending_break <= 1'b1;
                            end else if (shift_reg == 8'hE0) begin
                                pending_ext <= 1'b1;
                            end else begin
                                scan_code_r   <= shift_reg;
                                break_flag_r  <= pending_break;
                                ext_flag_r    <= pending_ext;
                                scan_valid_r  <= 1'b1;
                                pending_break <= 1'b0;
                                pending_ext   <= 1'b0;
                            end
                        end else begin
                            frame_err_r   <= 1'b1;
                            pending_break <= 1'b0;
                            pending_ext   <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (timeout) begin
                // Stalled frame: drop the partial byte and any prefix it belonged to.
                state         <= IDLE;
                frame_err_r   <= 1'b1;
                pending_break <= 1'b0;
                pending_ext   <= 1'b0;
            end
        end
    end

    assign bus.scan_code  = scan_code_r;
    assign bus.scan_valid = scan_valid_r;
    assign bus.break_flag = break_flag_r;
    assign bus.ext_flag   = ext_flag_r;
    assign bus.frame_err  = frame_err_r;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench for ps2_frame_receiver: expected events are queued as frames are sent
// and compared by a negedge monitor whenever the receiver pulses.
module tb_ps2_frame_receiver;

    localparam int unsigned TO   = 300;
    localparam int          HALF = 10;

    typedef enum logic {EV_VALID, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n;
    ev_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic last_pulse = 1'b0;

    always #5 clk = ~clk;

    ps2_frame_receiver_if bus ();

    ps2_frame_receiver #(.TIMEOUT_CYCLES(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_valid(input logic [7:0] code, input logic brk, input logic ext);
        ev_t e;
        e.kind = EV_VALID;
        e.code = code;
        e.brk  = brk;
        e.ext  = ext;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        ev_t e;
        e.kind = EV_ERR;
        e.code = 8'h00;
        e.brk  = 1'b0;
        e.ext  = 1'b0;
        exp_q.push_back(e);
    endtask

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (last_pulse)
                check("pulse_width", 32'({bus.scan_valid, bus.frame_err}), 32'd0);
            if (bus.scan_valid === 1'b1 || bus.frame_err === 1'b1) begin
                ev_t e;
                check("valid_err_exclusive", 32'(bus.scan_valid & bus.frame_err), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'({bus.scan_valid, bus.frame_err}), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", 32'(bus.frame_err), 32'(e.kind == EV_ERR));
                    if (e.kind == EV_VALID) begin
                        check("scan_code", 32'(bus.scan_code), 32'(e.code));
                        check("break_flag", 32'(bus.break_flag), 32'(e.brk));
                        check("ext_flag", 32'(bus.ext_flag), 32'(e.ext));
                    end
                end
            end
            last_pulse = bus.scan_valid | bus.frame_err;
        end else begin
            last_pulse = 1'b0;
        end
    end

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        bus.ps2_data = b;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    // Stop bit: the receiver's pulse must appear 3 negedges after the pin falls
    // (two synchroniser stages, then the registered output).
    task automatic ps2_stop(input logic b, input logic expect_out);
        int  lat  = 0;
        logic seen = 1'b0;
        @(negedge clk);
        bus.ps2_data = b;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b0;
        for (int k = 0; k < HALF; k++) begin
            @(negedge clk);
            if (!seen && (bus.scan_valid === 1'b1 || bus.frame_err === 1'b1)) begin
                seen = 1'b1;
                lat  = k + 1;
            end
        end
        if (expect_out)
            check("stop_latency", 32'(lat), 32'd3);
        else
            check("prefix_no_output", 32'(seen), 32'd0);
        bus.ps2_clk = 1'b1;
        @(negedge clk);
        bus.ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop,
                              input logic expect_out);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_stop(stop, expect_out);
        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        reset_n      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_scan_code", 32'(bus.scan_code), 32'h00);
        check("rst_scan_valid", 32'(bus.scan_valid), 32'd0);
        check("rst_break_flag", 32'(bus.break_flag), 32'd0);
        check("rst_ext_flag", 32'(bus.ext_flag), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Plain make code.
        push_valid(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1);

        // Break prefix folds into the next byte.
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        push_valid(8'h1C, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1);

        // Extended break, then the flags are cleared for the next byte.
        send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        push_valid(8'h75, 1'b1, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1, 1'b1);
        push_valid(8'h75, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b1, 1'b1);

        // Parity error clears a pending prefix and leaves scan_code alone.
        send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
        push_err();
        send_frame(8'h1C, 1'b1, 1'b1, 1'b1);
        check("scan_code_held", 32'(bus.scan_code), 32'h75);
        check("ext_flag_held", 32'(bus.ext_flag), 32'd0);
        push_valid(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1);

        // Stop-bit error.
        push_err();
        send_frame(8'h29, 1'b0, 1'b0, 1'b1);

        // Stalled frame after a break prefix: start + 5 data bits, then clock idles high.
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        push_err();
        begin
            int   k = HALF;
            logic in_window;
            ps2_bit(1'b0);
            for (int i = 0; i < 5; i++) ps2_bit(1'(8'h29 >> i));
            while (bus.frame_err !== 1'b1 && k < int'(TO) + 50) begin
                @(negedge clk);
                k++;
            end
            // k counts from the pin edge; the receiver sees that edge 2 cycles later.
            in_window = (k - 2 >= int'(TO) - 3) && (k - 2 <= int'(TO) + 3);
            checks++;
            assert (in_window) else begin
                errors++;
                $error("FAIL timeout_latency: observed %0d cycles after edge, expected %0d..%0d",
                       k - 2, int'(TO) - 3, int'(TO) + 3);
            end
        end
        repeat (5) @(negedge clk);
        check("timeout_queue_drained", 32'(exp_q.size()), 32'd0);
        push_valid(8'h29, 1'b0, 1'b0);
        send_frame(8'h29, 1'b0, 1'b1, 1'b1);

        // Reset mid-frame after a break prefix and data bits 0..3 of 0xF0.
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'(8'hF0 >> i));
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_scan_code", 32'(bus.scan_code), 32'h00);
        check("midrst_scan_valid", 32'(bus.scan_valid), 32'd0);
        check("midrst_break_flag", 32'(bus.break_flag), 32'd0);
        check("midrst_ext_flag", 32'(bus.ext_flag), 32'd0);
        check("midrst_frame_err", 32'(bus.frame_err), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        push_valid(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1);

        repeat (20) @(negedge clk);
        check("final_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_frame_receiver.md
PS2_FRAME_RECEIVER -- requirements
Module: ps2_frame_receiver

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 100000, clk cycles without a ps2_clk falling edge before an open frame is abandoned (1 ms at 100 MHz).
REQ-002 SHALL have port: clk  input  1  100 MHz system clock; all logic on rising edge.
REQ-003 SHALL have port: reset_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port: ps2_clk  input  1  raw PS/2 clock pin, asynchronous; the block never drives it.
REQ-005 SHALL have port: ps2_data  input  1  raw PS/2 data pin, asynchronous; the block never drives it.
REQ-006 SHALL have port: scan_code  output  8  last accepted non-prefix byte.
REQ-007 SHALL have port: scan_valid  output  1  one-cycle pulse; scan_code, break_flag and ext_flag are valid in this cycle.
REQ-008 SHALL have port: break_flag  output  1  byte was preceded by 0xF0 (key release).
REQ-009 SHALL have port: ext_flag  output  1  byte was preceded by 0xE0 (extended key).
REQ-010 SHALL have port: frame_err  output  1  one-cycle pulse on a parity error, stop-bit error or timeout.

Function
REQ-011 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer; sampling uses only synchronized values.
REQ-012 SHALL detect a falling edge when the synchronized ps2_clk is 0 and its registered previous value is 1; data is sampled in that same cycle.
REQ-013 SHALL use FSM states IDLE, DATA, PARITY, STOP; transitions occur only on a detected falling edge or a timeout.
REQ-014 SHALL, in IDLE: data=0 -> DATA with bit counter=0; data=1 -> stay in IDLE with no error.
REQ-015 SHALL, in DATA: shift data in LSB first; on the 8th bit (counter 7) go to PARITY; counter is 3 bits and never wraps mid-frame.
REQ-016 SHALL, in PARITY: record parity_ok = (XOR of 8 data bits XOR sampled bit) == 1 (odd parity); go to STOP.
REQ-017 SHALL, in STOP: go to IDLE; the frame is good only if parity_ok=1 and the sampled stop bit is 1; otherwise frame_err pulses.
REQ-018 SHALL treat a good byte 0xF0 as a prefix: set pending_break and emit no scan_valid.
REQ-019 SHALL treat a good byte 0xE0 as a prefix: set pending_ext and emit no scan_valid.
REQ-020 SHALL, for any other good byte: set scan_code, break_flag=pending_break and ext_flag=pending_ext, pulse scan_valid, then clear both pending flags.
REQ-021 SHALL register outputs so that scan_valid/frame_err go high exactly 1 cycle after the cycle in which the stop-bit falling edge is detected.
REQ-022 SHALL hold scan_code, break_flag and ext_flag stable between scan_valid pulses.
REQ-023 SHALL clear the idle counter on every falling edge and saturate it at TIMEOUT_CYCLES; in IDLE the counter is ignored.
REQ-024 SHALL, when the counter reaches TIMEOUT_CYCLES in a non-IDLE state: go to IDLE, pulse frame_err, discard the partial byte and clear the pending flags.
REQ-025 SHALL, on any frame error: clear the pending flags; scan_valid and frame_err are never high in the same cycle.
REQ-026 SHALL, when a timeout and a falling edge occur in the same cycle, let the edge take priority, with no timeout.

Reset
REQ-027 SHALL, while reset_n=0 at a clk edge: state=IDLE, counters=0, synchronizers and previous-clock register=1, pending flags=0, scan_code=0x00, scan_valid=0, break_flag=0, ext_flag=0, frame_err=0.
REQ-028 SHALL, when reset is asserted mid-frame: abandon the frame, emit no pulse, and accept the next start bit normally after reset_n returns to 1.

Verification
REQ-029 SHALL cover: frame 0x1C, parity 0, stop 1 -> one scan_valid, scan_code=0x1C, break_flag=0, ext_flag=0, frame_err stays 0.
REQ-030 SHALL cover: frames 0xF0 then 0x1C -> a single scan_valid, after the second frame only, with scan_code=0x1C, break_flag=1, ext_flag=0.
REQ-031 SHALL cover: frames 0xE0, 0xF0, 0x75 -> a single scan_valid, scan_code=0x75, break_flag=1, ext_flag=1; a following 0x75 frame gives both flags 0.
REQ-032 SHALL cover: 0x1C with parity 1 -> frame_err pulses once, no scan_valid, scan_code stays at its previous value.
REQ-033 SHALL cover: start bit plus 5 data bits, then ps2_clk held high -> frame_err pulses TIMEOUT_CYCLES (±3) cycles after the last edge; the next good 0x29 frame is received correctly.
REQ-034 SHALL cover: reset_n=0 for 2 cycles after data bit 3 of 0xF0 -> all outputs 0; a subsequent good 0x1C frame gives break_flag=0.
